// File: rtl/tinsel_accel_flit_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tinsel_accel_flit_arbiter_if : requester/output bundle of the flit arbiter  |
// | Rev 1.0 ; msg_count exists only when TINSEL_ACCEL_ARB_STATS_EN is defined   |
// +----------------------------------------------------------------------------+
interface tinsel_accel_flit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 64,
  parameter int LOG_REQ = $clog2(NUM_REQ)
);
  logic [NUM_REQ*FLIT_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_ready;
  logic [FLIT_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      locked;
  logic [LOG_REQ-1:0]        lock_owner;
`ifdef TINSEL_ACCEL_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     msg_count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, locked, lock_owner, msg_count
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, locked, lock_owner, msg_count
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, locked, lock_owner
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, locked, lock_owner
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tinsel_accel_flit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tinsel_accel_flit_arbiter : message-granular round-robin flit arbiter       |
// | Rev 1.0 ; TINSEL_ACCEL_ARB_STATS_EN adds per-requester message counters     |
// +----------------------------------------------------------------------------+
module tinsel_accel_flit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 64,
  parameter int LOG_REQ = $clog2(NUM_REQ)
) (
  input wire                         clk,
  input wire                         rst_n,
  tinsel_accel_flit_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LOG_REQ-1:0] rr_q, rr_d;
  logic [LOG_REQ-1:0] owner_q, owner_d;
  logic               out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]  out_data_q, out_data_d;

  logic [LOG_REQ-1:0] w_grant;
  logic               w_any_valid;
  logic [LOG_REQ-1:0] w_sel;
  logic               w_sel_en;
  logic               w_can_accept;
  logic [NUM_REQ-1:0] w_in_ready;
  logic               w_accept;
  logic [FLIT_W-1:0]  w_flit;

  function automatic logic [LOG_REQ-1:0] wrap_add(input logic [LOG_REQ-1:0] base,
                                                  input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return LOG_REQ'(s);
  endfunction

  // Walk downward so the lowest offset from rr that is valid wins.
  always_comb begin
    w_grant     = rr_q;
    w_any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.in_valid[wrap_add(rr_q, k)]) begin
        w_grant     = wrap_add(rr_q, k);
        w_any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_can_accept = !out_valid_q || bus.out_ready;
    w_sel        = (state_q == LOCKED) ? owner_q : w_grant;
    // The owner keeps the port while locked even when it has nothing to send.
    w_sel_en     = (state_q == LOCKED) ? 1'b1 : w_any_valid;

    w_in_ready = '0;
    w_flit     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_in_ready[i] = rst_n && w_can_accept && w_sel_en && (w_sel == LOG_REQ'(i));
      if (w_sel == LOG_REQ'(i)) w_flit = bus.in_data[i*FLIT_W +: FLIT_W];
    end
    w_accept = |(bus.in_valid & w_in_ready);

    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = w_flit;
      owner_d     = w_sel;
      rr_d        = wrap_add(w_sel, 1);
      state_d     = w_flit[1] ? LOCKED : IDLE;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.lock_owner = owner_q;

`ifdef TINSEL_ACCEL_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] cnt_q;
      always_ff @(negedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (w_accept && !w_flit[1] && (w_sel == LOG_REQ'(gi)) &&
                     (cnt_q != 16'hFFFF)) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      assign bus.msg_count[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_tinsel_accel_flit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tinsel_accel_flit_arbiter : directed self-checking bench for the arbiter |
// | Rev 1.0 ; stats section runs only with TINSEL_ACCEL_ARB_STATS_EN defined    |
// +----------------------------------------------------------------------------+
module tb_tinsel_accel_flit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FLIT_W  = 16;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  tinsel_accel_flit_arbiter_if #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W)) bus ();

  tinsel_accel_flit_arbiter #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flit layout: [15:12] source, [11:4] sequence, [1] notFinalFlit, [0] isIdleToken.
  function automatic logic [FLIT_W-1:0] mk(input int src, input int seq,
                                           input bit nff, input bit idle);
    return {src[3:0], seq[7:0], 2'b00, nff, idle};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [FLIT_W-1:0] d);
    bus.in_valid[i]                 = v;
    bus.in_data[i*FLIT_W +: FLIT_W] = d;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, mk(i, 0, 1'b0, 1'b0));

    // Reset with everyone requesting
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_owner", 32'(bus.lock_owner), 32'h0);

    // Round robin 0,1,2,3,0 with one flit per cycle
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr_ready", 32'(bus.in_ready), 32'(1) << (c % 4));
      tick();
      chk("rr_out_valid", 32'(bus.out_valid), 32'h1);
      chk("rr_out_data", 32'(bus.out_data), 32'(mk(c % 4, c / 4, 1'b0, 1'b0)));
      set_req(c % 4, 1'b1, mk(c % 4, c / 4 + 1, 1'b0, 1'b0));
    end

    // Lock: req1 three-flit message while req0/req2 compete
    set_req(0, 1'b1, mk(0, 8, 1'b0, 1'b0));
    set_req(1, 1'b1, mk(1, 1, 1'b1, 1'b0));
    set_req(2, 1'b1, mk(2, 8, 1'b0, 1'b0));
    set_req(3, 1'b0, '0);
    #1 chk("lock_ready_f0", 32'(bus.in_ready), 32'h2);
    tick();
    chk("lock_out_f0", 32'(bus.out_data), 32'(mk(1, 1, 1'b1, 1'b0)));
    chk("lock_locked_f0", 32'(bus.locked), 32'h1);
    chk("lock_owner_f0", 32'(bus.lock_owner), 32'h1);
    set_req(1, 1'b1, mk(1, 2, 1'b1, 1'b0));
    #1 chk("lock_ready_f1", 32'(bus.in_ready), 32'h2);
    tick();
    chk("lock_out_f1", 32'(bus.out_data), 32'(mk(1, 2, 1'b1, 1'b0)));
    chk("lock_locked_f1", 32'(bus.locked), 32'h1);
    set_req(1, 1'b1, mk(1, 3, 1'b0, 1'b0));
    #1 chk("lock_ready_f2", 32'(bus.in_ready), 32'h2);
    tick();
    chk("lock_out_f2", 32'(bus.out_data), 32'(mk(1, 3, 1'b0, 1'b0)));
    chk("lock_locked_f2", 32'(bus.locked), 32'h0);
    set_req(1, 1'b0, '0);
    #1 chk("lock_next_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("lock_next_out", 32'(bus.out_data), 32'(mk(2, 8, 1'b0, 1'b0)));
    chk("lock_next_owner", 32'(bus.lock_owner), 32'h2);

    // Owner gap: req2 idles mid-message, nobody else may enter
    set_req(0, 1'b0, '0);
    set_req(2, 1'b1, mk(2, 1, 1'b1, 1'b0));
    #1 chk("gap_ready_f0", 32'(bus.in_ready), 32'h4);
    tick();
    chk("gap_locked_f0", 32'(bus.locked), 32'h1);
    chk("gap_owner_f0", 32'(bus.lock_owner), 32'h2);
    set_req(2, 1'b0, '0);
    set_req(0, 1'b1, mk(0, 9, 1'b0, 1'b0));
    set_req(1, 1'b1, mk(1, 9, 1'b0, 1'b0));
    set_req(3, 1'b1, mk(3, 9, 1'b0, 1'b1));
    for (int g = 0; g < 2; g++) begin
      #1 chk("gap_ready_hold", 32'(bus.in_ready), 32'h4);
      tick();
      chk("gap_locked_hold", 32'(bus.locked), 32'h1);
      chk("gap_out_valid", 32'(bus.out_valid), 32'h0);
    end
    set_req(2, 1'b1, mk(2, 2, 1'b0, 1'b0));
    #1 chk("gap_ready_f1", 32'(bus.in_ready), 32'h4);
    tick();
    chk("gap_out_f1", 32'(bus.out_data), 32'(mk(2, 2, 1'b0, 1'b0)));
    chk("gap_locked_f1", 32'(bus.locked), 32'h0);
    set_req(2, 1'b0, '0);

    // Back-pressure freezes everything, then drains in order
    bus.out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_out_data", 32'(bus.out_data), 32'(mk(2, 2, 1'b0, 1'b0)));
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_resume_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk("bp_out_idle_token", 32'(bus.out_data), 32'(mk(3, 9, 1'b0, 1'b1)));
    set_req(3, 1'b0, '0);
    #1 chk("bp_ready_req0", 32'(bus.in_ready), 32'h1);
    tick();
    chk("bp_out_req0", 32'(bus.out_data), 32'(mk(0, 9, 1'b0, 1'b0)));
    set_req(0, 1'b0, '0);
    #1 chk("bp_ready_req1", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bp_out_req1", 32'(bus.out_data), 32'(mk(1, 9, 1'b0, 1'b0)));
    set_req(1, 1'b0, '0);

    // Reset in the middle of a req3 message
    set_req(3, 1'b1, mk(3, 1, 1'b1, 1'b0));
    #1 chk("mrst_ready_f0", 32'(bus.in_ready), 32'h8);
    tick();
    chk("mrst_locked_f0", 32'(bus.locked), 32'h1);
    chk("mrst_owner_f0", 32'(bus.lock_owner), 32'h3);
    rst_n = 1'b0;
    set_req(3, 1'b1, mk(3, 2, 1'b0, 1'b0));
    #1 chk("mrst_ready_in_rst", 32'(bus.in_ready), 32'h0);
    tick();
    chk("mrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mrst_locked", 32'(bus.locked), 32'h0);
    chk("mrst_owner", 32'(bus.lock_owner), 32'h0);
    rst_n = 1'b1;
    set_req(0, 1'b1, mk(0, 5, 1'b0, 1'b0));
    #1 chk("mrst_ready_req0", 32'(bus.in_ready), 32'h1);
    tick();
    chk("mrst_out_req0", 32'(bus.out_data), 32'(mk(0, 5, 1'b0, 1'b0)));
    chk("mrst_owner_req0", 32'(bus.lock_owner), 32'h0);

`ifdef TINSEL_ACCEL_ARB_STATS_EN
    // Saturating completed-message counter on req0
    rst_n        = 1'b0;
    bus.in_valid = '0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, mk(0, 0, 1'b0, 1'b0));
    repeat (70000) tick();
    set_req(0, 1'b0, '0);
    tick();
    chk("stats_req0_sat", 32'(bus.msg_count[15:0]), 32'hFFFF);
    chk("stats_req1", 32'(bus.msg_count[31:16]), 32'h0);
    chk("stats_req2", 32'(bus.msg_count[47:32]), 32'h0);
    chk("stats_req3", 32'(bus.msg_count[63:48]), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
